// File: rtl/bamboo_pkg.sv
// bamboo_pkg: shared register-file widths, index type and the x0 constant
package bamboo_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-write vector with set-over-clear priority and issue hazard check
// Ports: clk/rst; iss_* issuing instruction; wb_we/wb_rd write performed this cycle;
// iss_stall hazard; pending debug vector; byp_rs1_hit/byp_rs2_hit only with WB_BYPASS_EN.
module wb_scoreboard
  import bamboo_pkg::*;
#(
  parameter int NREG_P = bamboo_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rs1,
  input  logic [4:0]        iss_rs2,
  input  logic [4:0]        iss_rd,
  input  logic              iss_has_rd,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  output logic              iss_stall,
  output logic [NREG_P-1:0] pending
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_rs1_hit,
  output logic              byp_rs2_hit
`endif
);
  logic [NREG_P-1:0] pend_q, pend_d, set_m, clr_m, hz_m, excl_m;
  logic fire;
`ifdef WB_BYPASS_EN
  // the register being written right now is forwarded, so it is no longer a hazard
  assign excl_m = clr_m;
  assign byp_rs1_hit = wb_we & (iss_rs1 == wb_rd);
  assign byp_rs2_hit = wb_we & (iss_rs2 == wb_rd);
`else
  assign excl_m = '0;
`endif
  always_comb begin
    clr_m = wb_we ? NREG_P'(1) << wb_rd : '0;
    hz_m = pend_q & ~excl_m & ~NREG_P'(1);
    iss_stall = iss_valid & (hz_m[iss_rs1] | hz_m[iss_rs2] | (iss_has_rd & hz_m[iss_rd]));
    fire = iss_valid & !iss_stall;
    set_m = (fire & iss_has_rd & (iss_rd != REG_ZERO)) ? NREG_P'(1) << iss_rd : '0;
    // set applied after clear: a new producer outranks the retiring one
    pend_d = ((pend_q & ~clr_m) | set_m) & ~NREG_P'(1);
  end
  always_ff @(posedge clk)
    pend_q <= rst ? '0 : pend_d;
  assign pending = pend_q;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: two-source write-back arbiter driving the register file write port
// Ports: s0_* ALU and s1_* LSU valid/ready write-back requests; rf_we/rf_rd_sel/rf_w_val
// register file write port; iss_* issue hazard query, iss_stall result; pending debug vector.
// Macro WB_BYPASS_EN adds byp_rs1_hit/byp_rs2_hit/byp_val and same-cycle hazard bypass.
module regfile_wb_ctrl #(
  parameter int XLEN = bamboo_pkg::XLEN,
  parameter int NREG = bamboo_pkg::NREG,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0_valid,
  input  logic [4:0]      s0_rd,
  input  logic [XLEN-1:0] s0_data,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic [4:0]      s1_rd,
  input  logic [XLEN-1:0] s1_data,
  output logic            s1_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd_sel,
  output logic [XLEN-1:0] rf_w_val,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic [4:0]      iss_rd,
  input  logic            iss_has_rd,
  output logic            iss_stall,
  output logic [NREG-1:0] pending
`ifdef WB_BYPASS_EN
  ,
  output logic            byp_rs1_hit,
  output logic            byp_rs2_hit,
  output logic [XLEN-1:0] byp_val
`endif
);
  import bamboo_pkg::*;
  logic [2:0] starve_q, starve_d;
  logic g0, g1;
  always_comb begin
    // LSU wins by default; a starved ALU takes the port once the counter saturates
    g1 = !rst & s1_valid & !(s0_valid & (starve_q == 3'(STARVE_MAX)));
    g0 = !rst & s0_valid & !g1;
    s0_ready = g0;
    s1_ready = g1;
    rf_rd_sel = g1 ? s1_rd : g0 ? s0_rd : REG_ZERO;
    rf_w_val = g1 ? s1_data : g0 ? s0_data : '0;
    rf_we = (g0 | g1) & (rf_rd_sel != REG_ZERO);
    starve_d = (!s0_valid | g0) ? 3'd0 :
               (g1 & (starve_q < 3'(STARVE_MAX))) ? starve_q + 3'd1 : starve_q;
  end
  always_ff @(posedge clk)
    starve_q <= rst ? 3'd0 : starve_d;
  wb_scoreboard #(.NREG_P(NREG)) u_sb (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_has_rd(iss_has_rd),
    .wb_we(rf_we), .wb_rd(rf_rd_sel),
    .iss_stall(iss_stall), .pending(pending)
`ifdef WB_BYPASS_EN
    , .byp_rs1_hit(byp_rs1_hit), .byp_rs2_hit(byp_rs2_hit)
`endif
  );
`ifdef WB_BYPASS_EN
  assign byp_val = rf_w_val;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: scoreboard bench; stimulus queues expected grants, monitor checks handshakes
module tb_regfile_wb_ctrl;
  logic clk = 0, rst = 1;
  logic s0_valid = 0, s1_valid = 0, s0_ready, s1_ready;
  logic [4:0] s0_rd = 0, s1_rd = 0, rf_rd_sel;
  logic [31:0] s0_data = 0, s1_data = 0, rf_w_val, pending;
  logic rf_we, iss_valid = 0, iss_has_rd = 0, iss_stall;
  logic [4:0] iss_rs1 = 0, iss_rs2 = 0, iss_rd = 0;
`ifdef WB_BYPASS_EN
  logic byp_rs1_hit, byp_rs2_hit;
  logic [31:0] byp_val;
`endif
  typedef struct packed {logic [1:0] rdy; logic we; logic [4:0] rd; logic [31:0] data;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  regfile_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data), .s1_ready(s1_ready),
    .rf_we(rf_we), .rf_rd_sel(rf_rd_sel), .rf_w_val(rf_w_val),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_has_rd(iss_has_rd), .iss_stall(iss_stall), .pending(pending)
`ifdef WB_BYPASS_EN
    , .byp_rs1_hit(byp_rs1_hit), .byp_rs2_hit(byp_rs2_hit), .byp_val(byp_val)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    s0_valid = 0; s1_valid = 0; iss_valid = 0; iss_has_rd = 0;
    iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
  endtask

  task automatic wb(input bit src, input logic [4:0] rd, input logic [31:0] d);
    if (src) begin s1_valid = 1; s1_rd = rd; s1_data = d; end
    else begin s0_valid = 1; s0_rd = rd; s0_data = d; end
    q.push_back('{rdy: src ? 2'b10 : 2'b01, we: rd != 0, rd: rd, data: d});
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic has);
    iss_valid = 1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_has_rd = has;
  endtask

  always @(negedge clk)
    if (s0_ready | s1_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_grant: got rdy=%b rd=%0d expected none", {s1_ready, s0_ready}, rf_rd_sel);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("grant", {30'd0, s1_ready, s0_ready}, {30'd0, e.rdy});
        chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
        chk("rf_rd_sel", {27'd0, rf_rd_sel}, {27'd0, e.rd});
        chk("rf_w_val", rf_w_val, e.data);
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s1_tab [5];
    s1_tab = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h13};
    tick; tick;
    rst = 0;
    #3;
    chk("rst_we", {31'd0, rf_we}, 0);
    chk("rst_rdy", {30'd0, s1_ready, s0_ready}, 0);
    chk("rst_stall", {31'd0, iss_stall}, 0);
    chk("rst_pending", pending, 0);
    // single ALU request
    tick; wb(0, 5'd5, 32'hDEADBEEF);
    tick; idle;
    // both valid: LSU x3, starved ALU once, LSU again
    for (int i = 0; i < 5; i++) begin
      tick;
      s0_valid = 1; s0_rd = 5'd1; s0_data = 32'hA0;
      s1_valid = 1; s1_rd = 5'd2; s1_data = s1_tab[i];
      q.push_back(i == 3 ? exp_t'{2'b01, 1'b1, 5'd1, 32'hA0} : exp_t'{2'b10, 1'b1, 5'd2, s1_tab[i]});
    end
    tick; idle;
    // write to x0 handshakes without writing
    tick; wb(1, 5'd0, 32'h1234);
    tick; idle;
    #3 chk("x0_pending", pending, 0);
    // RAW stall until the cycle after write-back of rd 7
    tick; issue(0, 0, 5'd7, 1);
    #3 chk("iss7_stall", {31'd0, iss_stall}, 0);
    tick; issue(5'd7, 0, 0, 0);
    #3 chk("pend7_set", pending, 32'h80);
    chk("raw_stall1", {31'd0, iss_stall}, 1);
    tick;
    #3 chk("raw_stall2", {31'd0, iss_stall}, 1);
    tick; wb(1, 5'd7, 32'h77);
`ifdef WB_BYPASS_EN
    #3 chk("raw_stall_wb", {31'd0, iss_stall}, 0);
    chk("byp_rs1", {31'd0, byp_rs1_hit}, 1);
`else
    #3 chk("raw_stall_wb", {31'd0, iss_stall}, 1);
`endif
    tick; s1_valid = 0;
    #3 chk("pend7_clr", pending, 0);
    chk("raw_stall_after", {31'd0, iss_stall}, 0);
    // set and clear of rd 9 in the same cycle: set wins
    tick; idle; issue(0, 0, 5'd9, 1); wb(0, 5'd9, 32'h99);
    tick; idle;
    #3 chk("pend9_setwins", pending, 32'h200);
    // build pending = 0x480, then reset with an LSU request present
    tick; issue(0, 0, 5'd7, 1); wb(0, 5'd9, 32'h9A);
    tick; idle; issue(0, 0, 5'd10, 1);
    tick; idle;
    #3 chk("pend_480", pending, 32'h480);
    tick; rst = 1; s1_valid = 1; s1_rd = 5'd3; s1_data = 32'h55;
    #3 chk("rst_mid_we", {31'd0, rf_we}, 0);
    chk("rst_mid_rdy", {31'd0, s1_ready}, 0);
    tick; rst = 0; idle;
    #3 chk("rst_mid_pending", pending, 0);
`ifdef WB_BYPASS_EN
    tick; issue(0, 0, 5'd4, 1);
    tick; idle; issue(0, 5'd4, 0, 0); wb(0, 5'd4, 32'h44);
    #3 chk("byp_stall", {31'd0, iss_stall}, 0);
    chk("byp_rs2", {31'd0, byp_rs2_hit}, 1);
    chk("byp_val", byp_val, 32'h44);
    tick; idle;
`endif
    tick; tick;
    chk("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
